// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: one-op-at-a-time sequencer between the FP execute stage and the FPU.
// Optional WAIT-state timeout (forced qNaN error completion) is built when FPU_TIMEOUT_EN is defined.
module fpu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_sel,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_sel,
    output logic             fpu_stall,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_overflow,
    input  logic             fpu_underflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_flags,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        fpu_a_q, fpu_a_d;
    logic [31:0]        fpu_b_q, fpu_b_d;
    logic [1:0]         fpu_sel_q, fpu_sel_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [1:0]         rsp_flags_q, rsp_flags_d;
    logic               expired_s;

`ifdef FPU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rsp_err_q, rsp_err_d;

    // WAIT-cycle counter: zero outside WAIT, so it is clear on every entry to WAIT
    always_comb begin
        cnt_d = '0;
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = '0;
        end
    end

    assign expired_s = (state_q == ST_WAIT) && (cnt_q == CNT_LAST);

    // Error flag: a real completion always wins over expiry in the same cycle
    always_comb begin
        rsp_err_d = rsp_err_q;
        if (state_q == ST_WAIT) begin
            if (fpu_done) begin
                rsp_err_d = 1'b0;
            end else if (expired_s) begin
                rsp_err_d = 1'b1;
            end else begin
                rsp_err_d = rsp_err_q;
            end
        end else begin
            rsp_err_d = rsp_err_q;
        end
    end

    // Timeout counter and error flag registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign expired_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Next-state and datapath capture for the IDLE/ISSUE/WAIT/RESP sequence
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        fpu_sel_d   = fpu_sel_q;
        tag_d       = tag_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = ST_ISSUE;
                    req_ready_d = 1'b0;
                    fpu_a_d     = req_a;
                    fpu_b_d     = req_b;
                    fpu_sel_d   = req_sel;
                    tag_d       = req_tag;
                end else begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            // fpu_done is deliberately ignored here: it may still reflect the previous op
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_done) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = fpu_result;
                    rsp_flags_d = {fpu_overflow, fpu_underflow};
                end else if (expired_s) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = QNAN;
                    rsp_flags_d = 2'b00;
                end else begin
                    state_d     = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer state, handshake flags, FPU operand and response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            fpu_a_q     <= 32'h0;
            fpu_b_q     <= 32'h0;
            fpu_sel_q   <= 2'b00;
            tag_q       <= '0;
            rsp_data_q  <= 32'h0;
            rsp_flags_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            fpu_sel_q   <= fpu_sel_d;
            tag_q       <= tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    // Stall the divider only while a finished result is being held back by the consumer
    assign fpu_stall = rsp_valid_q & ~rsp_ready;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign fpu_a     = fpu_a_q;
    assign fpu_b     = fpu_b_q;
    assign fpu_sel   = fpu_sel_q;
    assign rsp_tag   = tag_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a table-driven FPU stand-in and an iterative divider model.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a, req_b;
    logic [1:0]  req_sel;
    logic [4:0]  req_tag;
    logic [31:0] fpu_a, fpu_b;
    logic [1:0]  fpu_sel;
    logic        fpu_stall;
    logic        fpu_done;
    logic [31:0] fpu_result;
    logic        fpu_overflow, fpu_underflow;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic [1:0]  rsp_flags;
    logic        rsp_err;

    fpu_issue_ctrl #(.TIMEOUT_CYCLES(8), .TAG_W(5)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_tag(req_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_stall(fpu_stall),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  sel;
        logic [4:0]  tag;
        logic [31:0] data;
        logic [1:0]  flags;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic busy    = 1'b0;
    logic rv_prev = 1'b0;

    // FPU stand-in: known answers for the operand patterns used below, junk otherwise
    logic        man_mode = 1'b0;
    logic        man_done = 1'b0;
    logic [31:0] man_res  = 32'h0;
    logic [7:0]  div_cnt  = 8'hFF;
    logic [33:0] ref_s;

    function automatic logic [33:0] fpu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        logic [65:0] k;
        k = {s, a, b};
        case (k)
            {2'b00, 32'h3F800000, 32'h40000000}: return {2'b00, 32'h40400000};
            {2'b00, 32'h3F800000, 32'h3F800000}: return {2'b00, 32'h40000000};
            {2'b01, 32'h40400000, 32'h3F800000}: return {2'b00, 32'h40000000};
            {2'b10, 32'h40000000, 32'h40400000}: return {2'b00, 32'h40C00000};
            {2'b10, 32'h7F000000, 32'h7F000000}: return {2'b10, 32'h7F800000};
            {2'b10, 32'h00800000, 32'h00800000}: return {2'b01, 32'h00000000};
            {2'b11, 32'h41200000, 32'h40000000}: return {2'b00, 32'h40A00000};
            default:                             return {2'b11, 32'hBAD0BAD0};
        endcase
    endfunction

    assign ref_s         = fpu_ref(fpu_a, fpu_b, fpu_sel);
    assign fpu_result    = man_mode ? man_res : ref_s[31:0];
    assign fpu_overflow  = man_mode ? 1'b0 : ref_s[33];
    assign fpu_underflow = man_mode ? 1'b0 : ref_s[32];
    assign fpu_done      = man_mode ? man_done : ((fpu_sel == 2'b11) ? (div_cnt == 8'd5) : 1'b1);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Divider model restarts on acceptance and freezes while stalled; cycle counter and busy tracking
    always @(posedge clk) begin
        if (req_valid && req_ready) div_cnt <= 8'd0;
        else if (!fpu_stall && div_cnt != 8'hFF) div_cnt <= div_cnt + 8'd1;
        if (!rstn) begin
            busy <= 1'b0;
        end else if (req_valid && req_ready) begin
            busy    <= 1'b1;
            acc_cyc <= cyc;
        end else if (rsp_valid && rsp_ready) begin
            busy <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    // Response monitor: operand hold, latency, response stability, stall, and scoreboard pop
    always @(negedge clk) begin
        if (rstn) begin
            if (busy && sb.size() > 0) begin
                check_eq("fpu_a_hold", {32'h0, fpu_a}, {32'h0, sb[0].a});
                check_eq("fpu_b_hold", {32'h0, fpu_b}, {32'h0, sb[0].b});
                check_eq("fpu_sel_hold", {62'h0, fpu_sel}, {62'h0, sb[0].sel});
            end
            if (rsp_valid && !rv_prev && sb.size() > 0 && sb[0].lat >= 0)
                check_eq("latency", 64'(cyc - acc_cyc), 64'(sb[0].lat));
            if (rsp_valid && sb.size() > 0) begin
                check_eq("rsp_data", {32'h0, rsp_data}, {32'h0, sb[0].data});
                check_eq("req_ready_resp", {63'h0, req_ready}, 64'h0);
                check_eq("stall_resp", {63'h0, fpu_stall}, {63'h0, ~rsp_ready});
                if (rsp_ready) begin
                    check_eq("rsp_tag", {59'h0, rsp_tag}, {59'h0, sb[0].tag});
                    check_eq("rsp_flags", {62'h0, rsp_flags}, {62'h0, sb[0].flags});
                    check_eq("rsp_err", {63'h0, rsp_err}, {63'h0, sb[0].err});
                    void'(sb.pop_front());
                end
            end
            if (!rsp_valid)
                check_eq("stall_idle", {63'h0, fpu_stall}, 64'h0);
            if (sb.size() == 0 && !busy)
                check_eq("no_spurious_rsp", {63'h0, rsp_valid}, 64'h0);
        end
        rv_prev <= rsp_valid;
    end

    task automatic issue_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                             input logic [4:0] tag, input logic [31:0] data, input logic [1:0] flags,
                             input logic err, input int lat);
        exp_t e;
        bit   rdy;
        e.a = a; e.b = b; e.sel = sel; e.tag = tag;
        e.data = data; e.flags = flags; e.err = err; e.lat = lat;
        sb.push_back(e);
        req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel; req_tag = tag;
        rdy = 1'b0;
        for (int i = 0; i < 20 && !rdy; i++) begin
            @(negedge clk);
            rdy = req_ready;
        end
        if (!rdy) check_eq("req_ready_wait", 64'h0, 64'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check_eq("drain", 64'(sb.size()), 64'h0);
            sb.delete();
        end
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                          input logic [4:0] tag, input logic [31:0] data, input logic [1:0] flags,
                          input logic err, input int lat, input int hold);
        bit seen;
        rsp_ready = (hold == 0);
        issue_req(a, b, sel, tag, data, flags, err, lat);
        if (hold > 0) begin
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                seen = rsp_valid;
            end
            repeat (hold) @(posedge clk);
            #1;
            rsp_ready = 1'b1;
        end
        wait_drain();
    endtask

    initial begin
        rstn = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1; req_a = 32'h3F800000; req_b = 32'h40000000; req_sel = 2'b00; req_tag = 5'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", {63'h0, req_ready}, 64'h1);
        check_eq("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check_eq("rst_rsp_err", {63'h0, rsp_err}, 64'h0);
        check_eq("rst_stall", {63'h0, fpu_stall}, 64'h0);
        check_eq("rst_fpu_ab", {fpu_a, fpu_b}, 64'h0);
        check_eq("rst_fpu_sel", {62'h0, fpu_sel}, 64'h0);
        check_eq("rst_rsp_data", {32'h0, rsp_data}, 64'h0);
        check_eq("rst_rsp_tag_flags", {57'h0, rsp_tag, rsp_flags}, 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        run_op(32'h3F800000, 32'h40000000, 2'b00, 5'd5,  32'h40400000, 2'b00, 1'b0, 3, 0);
        run_op(32'h40000000, 32'h40400000, 2'b10, 5'd12, 32'h40C00000, 2'b00, 1'b0, 3, 10);
        run_op(32'h41200000, 32'h40000000, 2'b11, 5'd9,  32'h40A00000, 2'b00, 1'b0, 7, 0);
        run_op(32'h7F000000, 32'h7F000000, 2'b10, 5'd31, 32'h7F800000, 2'b10, 1'b0, 3, 0);
        run_op(32'h40400000, 32'h3F800000, 2'b01, 5'd7,  32'h40000000, 2'b00, 1'b0, 3, 0);
        run_op(32'h00800000, 32'h00800000, 2'b10, 5'd3,  32'h00000000, 2'b01, 1'b0, 3, 2);

        // Stale done during ISSUE must be ignored; capture happens on the later pulse
        man_mode = 1'b1; man_done = 1'b0; man_res = 32'hDEADBEEF;
        issue_req(32'h3F800000, 32'h3F800000, 2'b00, 5'd17, 32'h40000000, 2'b00, 1'b0, 7);
        man_done = 1'b1;
        @(posedge clk); #1;
        man_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stale_no_rsp", {63'h0, rsp_valid}, 64'h0);
            @(posedge clk); #1;
        end
        man_done = 1'b1; man_res = 32'h40000000;
        @(posedge clk); #1;
        man_done = 1'b0; man_res = 32'hDEADBEEF;
        wait_drain();
        man_mode = 1'b0;

`ifdef FPU_TIMEOUT_EN
        man_mode = 1'b1; man_done = 1'b0; man_res = 32'h12345678;
        run_op(32'h3F800000, 32'h40000000, 2'b00, 5'd11, 32'h7FC00000, 2'b00, 1'b1, 10, 0);
        man_res = 32'h3F800000;
        issue_req(32'h3F800000, 32'h40000000, 2'b00, 5'd12, 32'h3F800000, 2'b00, 1'b0, 10);
        repeat (8) @(posedge clk);
        #1; man_done = 1'b1;
        @(posedge clk); #1; man_done = 1'b0;
        wait_drain();
        man_mode = 1'b0;
`endif

        // Reset during the WAIT of a divide discards the op without a response
        issue_req(32'h41200000, 32'h40000000, 2'b11, 5'd20, 32'h40A00000, 2'b00, 1'b0, 7);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("midrst_req_ready", {63'h0, req_ready}, 64'h1);
        check_eq("midrst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("midrst_idle_ready", {63'h0, req_ready}, 64'h1);
            check_eq("midrst_idle_rv", {63'h0, rsp_valid}, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Initiator-side sequencer for the single-precision FPU. It accepts one FP operation at a time from the pipeline over a valid/ready request channel and drives operands, op select and stall into the FPU. It captures result and flags on the FPU's completion strobe and returns them over a valid/ready response channel. It sits between the FP execute stage and the FPU, and is the only block that drives FPU inputs.

## Interface
- TIMEOUT_CYCLES, 64, maximum WAIT-state cycles before forced error completion (used only with FPU_TIMEOUT_EN)
- TAG_W, 5, width of destination-register tag carried with each op
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request
- req_a  in  32  operand A, IEEE-754 single
- req_b  in  32  operand B
- req_sel  in  2  op: 00 add, 01 sub, 10 mul, 11 div
- req_tag  in  TAG_W  destination tag
- fpu_a  out  32  operand A to FPU
- fpu_b  out  32  operand B to FPU
- fpu_sel  out  2  op select to FPU
- fpu_stall  out  1  freeze to FPU iterative divider
- fpu_done  in  1  FPU completion (done_cal)
- fpu_result  in  32  FPU result
- fpu_overflow  in  1  FPU overflow flag
- fpu_underflow  in  1  FPU underflow flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  captured result
- rsp_tag  out  TAG_W  tag of completed op
- rsp_flags  out  2  {overflow, underflow}
- rsp_err  out  1  op completed by timeout

## Operation
- FSM states IDLE, ISSUE, WAIT, RESP; one-hot or binary is implementer's choice.
- IDLE: req_ready=1. On req_valid&&req_ready, register req_a/b/sel/tag into fpu_a/fpu_b/fpu_sel and the tag register, then go to ISSUE.
- ISSUE: operands held and fpu_done ignored. This blanks stale done from the previous op or from combinational settling. Go to WAIT unconditionally.
- WAIT: on fpu_done=1, capture fpu_result into rsp_data and {fpu_overflow,fpu_underflow} into rsp_flags, clear rsp_err, then go to RESP.
- RESP: rsp_valid=1. All rsp_* outputs are stable until rsp_valid&&rsp_ready, then go to IDLE.
- fpu_a/b/sel hold their last values in every state. They change only on request acceptance.
- fpu_stall=1 only in RESP while rsp_ready=0, so the divider does not advance while a result is pending. It is 0 in all other states.
- req_ready is asserted only in IDLE. There is no acceptance in the same cycle as a response handshake.
- Reset mid-operation: the FSM returns to IDLE and the in-flight op is discarded with no response.

## Timing
- Reset values:
  - req_ready=1 (IDLE).
  - rsp_valid=0, rsp_err=0, fpu_stall=0.
  - fpu_a=fpu_b=rsp_data=0, fpu_sel=00, rsp_tag=0, rsp_flags=0.
- Request accepted at edge N: ISSUE in N+1, WAIT from N+2.
- Add/sub/mul (combinational FPU path): fpu_done is high in the first WAIT cycle, and rsp_valid=1 from N+3.
- Div: rsp_valid rises one cycle after the first fpu_done seen in WAIT.
- Minimum initiation interval is 4 cycles: accept, ISSUE, WAIT, RESP with rsp_ready=1.
- rsp_valid is registered; no combinational path from fpu_done to rsp_*.
- req_ready depends only on state, with no combinational path from req_valid.

## Configuration
- FPU_TIMEOUT_EN defined:
  - An 8-bit-minimum WAIT counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without fpu_done, go to RESP with rsp_data=32'h7FC00000 (qNaN), rsp_flags=00, rsp_err=1.
  - fpu_done in the same cycle as expiry takes priority: normal completion with rsp_err=0.
- FPU_TIMEOUT_EN undefined:
  - No counter; WAIT persists until fpu_done.
  - rsp_err is tied 0.

## Test plan
- Reset with req_valid=1 → req_ready=1, rsp_valid=0, all outputs 0. After rstn release, the add 3F800000+40000000 (tag 5) is accepted. It returns rsp_data=40400000, rsp_tag=5, rsp_flags=00 at accept+3.
- Mul 40000000×40400000 with rsp_ready held 0 for 10 cycles → rsp_valid stays 1 and rsp_data=40C00000 stays stable. fpu_stall=1 throughout, req_ready=0. Handshake then returns to IDLE.
- Div 41200000÷40000000 → fpu_a/b/sel held stable until fpu_done. Result 40A00000 is returned exactly once.
- Stale done: fpu_done forced high during ISSUE and low afterwards, pulsed 5 cycles later → capture occurs on the later pulse only.
- Mul 7F000000×7F000000 → rsp_flags=10 (overflow).
- Two further cases:
  - FPU_TIMEOUT_EN with TIMEOUT_CYCLES=8 and fpu_done tied 0 → rsp_valid at 8 WAIT cycles with rsp_data=7FC00000, rsp_err=1. With fpu_done asserted on the expiry cycle → rsp_err=0.
  - rstn pulsed during WAIT of a div → no response, IDLE.
